rx_drain_ctrl: RTL and testbench

Read-side controller that sequences word transfers from the asynchronous FIFO's read port to the receiver. It runs entirely in the read clock domain. It pops one word when the FIFO is non-empty, captures it, and presents it to the receiver under a valid/ack handshake. A receiver that stalls too long gets bounded retries, then the word is dropped and counted.

---
 rtl/rx_drain_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rx_drain_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_drain_ctrl.sv
// -----------------------------------------------------------------------------
// rx_drain_ctrl
//
// Read-side controller between an asynchronous FIFO's read port and a
// receiver. Runs entirely in the read clock domain. It pops one word when
// the FIFO is non-empty, captures it, and offers it to the receiver under a
// valid/ack handshake. If the receiver stalls, the offer is withdrawn for one
// gap cycle and retried a bounded number of times. After the last retry the
// word is dropped and a saturating drop counter is bumped.
//
// Ports
//   clk           in   read-domain clock
//   rst           in   asynchronous active-high reset
//   enable        in   permits starting a new pop (looked at in IDLE only)
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_en    out  one-cycle FIFO pop strobe
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   rx_data       out  word presented to the receiver
//   rx_valid      out  rx_data valid, awaiting ack
//   ack           in   receiver accept (looked at in SEND only)
//   busy          out  high in every state except IDLE
//   drop_cnt      out  dropped-word count, saturates at 255
//
// All outputs are flops. fifo_rd_en, rx_valid and busy are decoded from the
// next state and registered, so they line up exactly with the state they
// describe without any combinational path from an input to an output.
// -----------------------------------------------------------------------------
module rx_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15,
    parameter int MAX_RETRY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  ack,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    // Timeout counter can reach TIMEOUT on the expiring cycle, hence +1.
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    // A retry counter of zero bits is not legal, so keep at least one bit.
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic [TMO_W-1:0]        tmo_cnt_s;
    logic [RTY_W-1:0]        rty_cnt_r;
    logic [RTY_W-1:0]        rty_cnt_s;
    logic                    drop_inc_s;
    logic                    load_s;

    logic                    fifo_rd_en_r;
    logic [DATA_WIDTH-1:0]   rx_data_r;
    logic                    rx_valid_r;
    logic                    busy_r;
    logic [7:0]              drop_cnt_r;

    // Next-state, counter and strobe decode for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        tmo_cnt_s  = tmo_cnt_r;
        rty_cnt_s  = rty_cnt_r;
        drop_inc_s = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rty_cnt_s = '0;
                if (enable && !fifo_empty) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                load_s    = 1'b1;
                tmo_cnt_s = '0;
                state_s   = ST_SEND;
            end
            ST_SEND: begin
                // ack is checked first so that an ack on the expiring cycle
                // still delivers the word.
                if (ack) begin
                    state_s = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                    if (tmo_cnt_r == TMO_LAST) begin
                        if (rty_cnt_r < RTY_MAX) begin
                            rty_cnt_s = rty_cnt_r + RTY_ONE;
                            state_s   = ST_GAP;
                        end else begin
                            drop_inc_s = 1'b1;
                            state_s    = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                tmo_cnt_s = '0;
                state_s   = ST_SEND;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
            rty_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            tmo_cnt_r <= tmo_cnt_s;
            rty_cnt_r <= rty_cnt_s;
        end
    end

    // Output flops: strobes follow the next state, data captured in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd_en_r <= 1'b0;
            rx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            rx_data_r    <= '0;
        end else begin
            fifo_rd_en_r <= (state_s == ST_POP);
            rx_valid_r   <= (state_s == ST_SEND);
            busy_r       <= (state_s != ST_IDLE);
            if (load_s) begin
                rx_data_r <= fifo_rd_data;
            end else begin
                rx_data_r <= rx_data_r;
            end
        end
    end

    // Saturating count of words abandoned after the final retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_inc_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign fifo_rd_en = fifo_rd_en_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign busy       = busy_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rx_drain_ctrl (default parameters 8/15/2).
// A small FIFO model feeds the DUT. A transaction-level reference model
// walks through each word as nested attempt/cycle loops and publishes the
// expected outputs for every cycle; the stimulus process compares them on
// every falling edge and also checks hand-computed totals per scenario.
// -----------------------------------------------------------------------------
module tb_rx_drain_ctrl;

    localparam int DW  = 8;
    localparam int TMO = 15;
    localparam int MR  = 2;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          enable       = 1'b0;
    logic          ack          = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = 8'h00;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic [7:0]    drop_cnt;

    rx_drain_ctrl #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .ack          (ack),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [7:0] mem [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 1;
    endtask

    // ---------------- reference model ----------------
    // exp_* describe the outputs for the cycle following the latest edge.
    logic       exp_rd_en = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_busy  = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic [7:0] exp_drop  = 8'h00;
    int         model_idx = 0;

    task automatic mtick(output bit ab);
        @(posedge clk or posedge rst);
        ab = rst;
    endtask

    // One word: pop cycle, load cycle, then up to MR+1 offer windows of TMO
    // cycles with a one-cycle gap between windows.
    task automatic run_word(output bit ab);
        logic [7:0] w;
        exp_rd_en = 1'b1;
        exp_busy  = 1'b1;
        mtick(ab);
        if (ab) return;
        exp_rd_en = 1'b0;
        w         = mem[model_idx];
        model_idx = model_idx + 1;
        mtick(ab);
        if (ab) return;
        exp_data = w;
        for (int a = 0; a <= MR; a++) begin
            exp_valid = 1'b1;
            for (int k = 0; k < TMO; k++) begin
                mtick(ab);
                if (ab) return;
                if (ack) begin
                    exp_valid = 1'b0;
                    exp_busy  = 1'b0;
                    return;
                end
            end
            exp_valid = 1'b0;
            if (a == MR) begin
                if (exp_drop != 8'd255) exp_drop = exp_drop + 8'd1;
                exp_busy = 1'b0;
                return;
            end
            mtick(ab);
            if (ab) return;
        end
    endtask

    initial begin : model
        bit ab;
        forever begin
            mtick(ab);
            if (!ab && enable && !fifo_empty) run_word(ab);
            if (ab) begin
                exp_rd_en = 1'b0;
                exp_valid = 1'b0;
                exp_busy  = 1'b0;
                exp_data  = 8'h00;
                exp_drop  = 8'h00;
            end
        end
    end

    // ---------------- checking / stimulus ----------------
    int         checks    = 0;
    int         failures  = 0;
    int         cyc_no    = 0;
    int         valid_cnt = 0;
    int         pulse_cnt = 0;
    int         dlv_cnt   = 0;
    int         pulse_cyc [0:511];
    logic [7:0] dlv       [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // One clock: compare against the model at the falling edge, log events,
    // then return just after the next rising edge for input changes.
    task automatic step();
        @(negedge clk);
        cyc_no = cyc_no + 1;
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd_en));
        chk("rx_valid",   32'(rx_valid),   32'(exp_valid));
        chk("busy",       32'(busy),       32'(exp_busy));
        chk("rx_data",    32'(rx_data),    32'(exp_data));
        chk("drop_cnt",   32'(drop_cnt),   32'(exp_drop));
        if (rx_valid) valid_cnt = valid_cnt + 1;
        if (fifo_rd_en) begin
            if (pulse_cnt < 512) pulse_cyc[pulse_cnt] = cyc_no;
            pulse_cnt = pulse_cnt + 1;
        end
        if (rx_valid && ack) begin
            if (dlv_cnt < 512) dlv[dlv_cnt] = rx_data;
            dlv_cnt = dlv_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : stim
        int bv, bp, bd;

        // Reset state
        run_cycles(3);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy",  32'(busy),     32'd0);
        chk("reset_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b0;
        run_cycles(2);

        // Single word, ack tied high
        bv = valid_cnt; bp = pulse_cnt; bd = dlv_cnt;
        ack = 1'b1; enable = 1'b1; push(8'hA5);
        run_cycles(8);
        chk("single_pops",  32'(pulse_cnt - bp), 32'd1);
        chk("single_valid", 32'(valid_cnt - bv), 32'd1);
        chk("single_dlvn",  32'(dlv_cnt - bd),   32'd1);
        chk("single_data",  32'(dlv[bd]),        32'hA5);
        chk("single_drop",  32'(drop_cnt),       32'd0);

        // Back-to-back, three words
        enable = 1'b0;
        run_cycles(2);
        bv = valid_cnt; bp = pulse_cnt; bd = dlv_cnt;
        push(8'h01); push(8'h02); push(8'h03); enable = 1'b1;
        run_cycles(16);
        chk("b2b_pops",  32'(pulse_cnt - bp), 32'd3);
        chk("b2b_gap0",  32'(pulse_cyc[bp+1] - pulse_cyc[bp]),   32'd4);
        chk("b2b_gap1",  32'(pulse_cyc[bp+2] - pulse_cyc[bp+1]), 32'd4);
        chk("b2b_w0",    32'(dlv[bd]),   32'h01);
        chk("b2b_w1",    32'(dlv[bd+1]), 32'h02);
        chk("b2b_w2",    32'(dlv[bd+2]), 32'h03);
        chk("b2b_valid", 32'(valid_cnt - bv), 32'd3);

        // Late ack on the 5th SEND cycle
        ack = 1'b0;
        bv = valid_cnt; bd = dlv_cnt;
        push(8'h3C);
        run_cycles(7);
        ack = 1'b1;
        run_cycles(6);
        chk("late_valid", 32'(valid_cnt - bv), 32'd5);
        chk("late_data",  32'(dlv[bd]),        32'h3C);
        chk("late_drop",  32'(drop_cnt),       32'd0);

        // Ack on the 15th SEND cycle collides with the timeout
        ack = 1'b0;
        bv = valid_cnt; bd = dlv_cnt;
        push(8'h77);
        run_cycles(17);
        ack = 1'b1;
        run_cycles(6);
        chk("coll_valid", 32'(valid_cnt - bv), 32'd15);
        chk("coll_dlvn",  32'(dlv_cnt - bd),   32'd1);
        chk("coll_data",  32'(dlv[bd]),        32'h77);
        chk("coll_drop",  32'(drop_cnt),       32'd0);

        // Drop path: three 15-cycle windows then a drop
        ack = 1'b0;
        bv = valid_cnt; bp = pulse_cnt;
        push(8'hD1);
        run_cycles(60);
        chk("drop_valid", 32'(valid_cnt - bv), 32'd45);
        chk("drop_pops",  32'(pulse_cnt - bp), 32'd1);
        chk("drop_cnt1",  32'(drop_cnt),       32'd1);
        chk("drop_idle",  32'(busy),           32'd0);

        // enable removed during SEND: word completes, no further pop
        bp = pulse_cnt; bd = dlv_cnt;
        push(8'h55); push(8'h66);
        run_cycles(4);
        enable = 1'b0;
        run_cycles(3);
        ack = 1'b1;
        run_cycles(10);
        chk("en_pops", 32'(pulse_cnt - bp), 32'd1);
        chk("en_data", 32'(dlv[bd]),        32'h55);
        chk("en_dlvn", 32'(dlv_cnt - bd),   32'd1);

        // Reset in the middle of SEND
        ack = 1'b0; enable = 1'b1;
        run_cycles(5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(rx_valid),   32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_rden",  32'(fifo_rd_en), 32'd0);
        chk("rst_data",  32'(rx_data),    32'd0);
        chk("rst_drop",  32'(drop_cnt),   32'd0);
        enable = 1'b0;
        run_cycles(2);
        rst = 1'b0;
        run_cycles(3);

        // 256 drops saturate the counter at 255
        bp = pulse_cnt;
        for (int i = 0; i < 256; i++) push(8'(i));
        enable = 1'b1;
        run_cycles(256 * 50 + 10);
        chk("sat_pops", 32'(pulse_cnt - bp), 32'd256);
        chk("sat_drop", 32'(drop_cnt),       32'd255);
        enable = 1'b0;
        run_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
